// File: rtl/message_overlay_if.sv
// Pixel-scan, control and drawing-request signals shared between the
// message_overlay drawer and its surrounding VGA pipeline.
interface message_overlay_if;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic        show_req;
    logic [1:0]  msg_sel;
    logic        clear;
    logic        drawingRequest;
    logic [7:0]  RGBout;
    logic        active;
    logic        reveal_done;

    modport master (
        output pixelX, pixelY, startOfFrame, show_req, msg_sel, clear,
        input  drawingRequest, RGBout, active, reveal_done
    );

    modport slave (
        input  pixelX, pixelY, startOfFrame, show_req, msg_sel, clear,
        output drawingRequest, RGBout, active, reveal_done
    );
endinterface

// File: rtl/message_overlay.sv
// Status-text overlay: four fixed bitmap messages drawn at a scaled position,
// revealed by a left-to-right column wipe; PAUSED blinks once fully shown.
module message_overlay #(
    parameter int unsigned MSG_W        = 65,
    parameter int unsigned MSG_H        = 16,
    parameter int unsigned SCALE_BITS   = 2,
    parameter int unsigned TOP_LEFT_X   = 192,
    parameter int unsigned TOP_LEFT_Y   = 208,
    parameter int unsigned REVEAL_STEP  = 4,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter logic [7:0]  FG_COLOR     = 8'hFF
) (
    input logic clk,
    input logic resetN,
    message_overlay_if.slave bus
);
    localparam int unsigned CNT_W   = $clog2(MSG_W + 1);
    localparam int unsigned SUM_W   = CNT_W + 1;
    localparam int unsigned BLINK_W = $clog2(BLINK_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, REVEAL, SHOW} state_t;

    state_t             state, state_next;
    logic [1:0]         msg_q, msg_next;
    logic [CNT_W-1:0]   reveal_cnt, reveal_next;
    logic [SUM_W-1:0]   reveal_sum;
    logic [BLINK_W-1:0] blink_cnt, blink_next;
    logic               blink_on, blink_on_next;
    logic               done_next, visible, draw_next;
    logic               draw_q, active_q, done_q;
    logic [7:0]         rgb_q;
    logic [11:0]        dx, dy, col, row;
    logic               hit;

    // 7x5 bold font; each font row spans two bitmap rows, MSB is leftmost.
    function automatic logic [34:0] glyph(input logic [7:0] ch);
        case (ch)
            "Y":     glyph = 35'b1110111_0111110_0011100_0011100_0011100;
            "O":     glyph = 35'b0111110_1100011_1100011_1100011_0111110;
            "U":     glyph = 35'b1100011_1100011_1100011_1100011_0111110;
            "W":     glyph = 35'b1100011_1100011_1101011_1111111_0110110;
            "I":     glyph = 35'b1111111_0011100_0011100_0011100_1111111;
            "N":     glyph = 35'b1100011_1110011_1111011_1101111_1100111;
            "L":     glyph = 35'b1100000_1100000_1100000_1100000_1111111;
            "S":     glyph = 35'b0111111_1100000_0111110_0000011_1111110;
            "E":     glyph = 35'b1111111_1100000_1111110_1100000_1111111;
            "P":     glyph = 35'b1111110_1100011_1111110_1100000_1100000;
            "A":     glyph = 35'b0111110_1100011_1111111_1100011_1100011;
            "D":     glyph = 35'b1111110_1100011_1100011_1100011_1111110;
            "V":     glyph = 35'b1100011_1100011_1100011_0110110_0011100;
            default: glyph = '0;
        endcase
    endfunction

    // Eight 8-column character cells (7 glyph + 1 gap) occupy cols 0..63.
    function automatic logic rom_bit(input logic [1:0] msg, input logic [11:0] r,
                                     input logic [11:0] c);
        logic [63:0] text;
        logic [34:0] sh;
        logic [2:0]  frow;
        logic [5:0]  sh_amt;
        case (msg)
            2'd0:    text = "YOU WIN ";
            2'd1:    text = "YOU LOSE";
            2'd2:    text = "PAUSED  ";
            default: text = "LEVEL UP";
        endcase
        frow    = 3'((r - 12'd2) >> 1);
        sh_amt  = {3'b000, frow} * 6'd7 + {3'b000, c[2:0]};
        sh      = glyph(text[{~c[5:3], 3'b000} +: 8]) << sh_amt;
        rom_bit = (r >= 12'd2) && (r <= 12'd11) && (c < 12'd64) && (c[2:0] != 3'd7) && sh[34];
    endfunction

    assign dx  = {1'b0, bus.pixelX} - 12'(TOP_LEFT_X);
    assign dy  = {1'b0, bus.pixelY} - 12'(TOP_LEFT_Y);
    assign col = dx >> SCALE_BITS;
    assign row = dy >> SCALE_BITS;
    assign hit = ({1'b0, bus.pixelX} >= 12'(TOP_LEFT_X)) && ({1'b0, bus.pixelY} >= 12'(TOP_LEFT_Y))
                 && (col < 12'(MSG_W)) && (row < 12'(MSG_H));

    assign reveal_sum = {1'b0, reveal_cnt} + SUM_W'(REVEAL_STEP);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            msg_q      <= '0;
            reveal_cnt <= '0;
            blink_cnt  <= '0;
            blink_on   <= 1'b1;
            draw_q     <= 1'b0;
            rgb_q      <= '0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_next;
            msg_q      <= msg_next;
            reveal_cnt <= reveal_next;
            blink_cnt  <= blink_next;
            blink_on   <= blink_on_next;
            draw_q     <= draw_next;
            rgb_q      <= FG_COLOR;
            active_q   <= (state_next != IDLE);
            done_q     <= done_next;
        end
    end

    // clear beats show_req, and a restart swallows a coincident startOfFrame.
    always_comb begin
        state_next    = state;
        msg_next      = msg_q;
        reveal_next   = reveal_cnt;
        blink_next    = blink_cnt;
        blink_on_next = blink_on;
        done_next     = 1'b0;
        if (bus.clear) begin
            state_next = IDLE;
        end else if (bus.show_req) begin
            state_next    = REVEAL;
            msg_next      = bus.msg_sel;
            reveal_next   = '0;
            blink_next    = '0;
            blink_on_next = 1'b1;
        end else begin
            unique case (state)
                REVEAL: begin
                    if (bus.startOfFrame) begin
                        if (reveal_sum >= SUM_W'(MSG_W)) begin
                            reveal_next = CNT_W'(MSG_W);
                            state_next  = SHOW;
                            done_next   = 1'b1;
                        end else begin
                            reveal_next = reveal_sum[CNT_W-1:0];
                        end
                    end
                end
                SHOW: begin
                    if (bus.startOfFrame && msg_q == 2'd2) begin
                        if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                            blink_next    = '0;
                            blink_on_next = ~blink_on;
                        end else begin
                            blink_next = blink_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        visible = 1'b0;
        unique case (state)
            REVEAL:  visible = (col < 12'(reveal_cnt));
            SHOW:    visible = blink_on;
            default: visible = 1'b0;
        endcase
        draw_next = hit && visible && rom_bit(msg_q, row, col);
    end

    assign bus.drawingRequest = draw_q;
    assign bus.RGBout         = rgb_q;
    assign bus.active         = active_q;
    assign bus.reveal_done    = done_q;
endmodule

// File: tb/tb_message_overlay.sv
// Directed bench for message_overlay: hand-computed pixel hits, reveal timing,
// PAUSED blink phases, event priority and asynchronous reset.
module tb_message_overlay;
    timeunit 1ns;
    timeprecision 1ps;

    logic clk = 1'b0;
    logic resetN;
    int   n_assert = 0;
    int   n_fail = 0;

    message_overlay_if bus ();

    message_overlay #(
        .MSG_W(65), .MSG_H(16), .SCALE_BITS(2), .TOP_LEFT_X(192), .TOP_LEFT_Y(208),
        .REVEAL_STEP(4), .BLINK_FRAMES(30), .FG_COLOR(8'hFF)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic probe(input string tag, input int x, input int y, input logic exp);
        bus.pixelX = 11'(x);
        bus.pixelY = 11'(y);
        tick();
        check(tag, 32'(bus.drawingRequest), 32'(exp));
        bus.pixelX = '0;
        bus.pixelY = '0;
    endtask

    task automatic frame();
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
    endtask

    task automatic show(input logic [1:0] m);
        bus.show_req = 1'b1;
        bus.msg_sel  = m;
        tick();
        bus.show_req = 1'b0;
        check("active_after_show", 32'(bus.active), 32'd1);
    endtask

    // Runs a full reveal from a fresh show_req: done only on the 17th frame.
    task automatic run_reveal(input string tag);
        int early = 0;
        for (int i = 0; i < 16; i++) begin
            frame();
            early += int'(bus.reveal_done);
        end
        check({tag, "_no_early_done"}, 32'(early), 32'd0);
        frame();
        check({tag, "_done_17th"}, 32'(bus.reveal_done), 32'd1);
        tick();
        check({tag, "_done_one_cycle"}, 32'(bus.reveal_done), 32'd0);
    endtask

    initial begin
        int bad;
        int early;
        resetN = 1'b0;
        bus.pixelX = '0;
        bus.pixelY = '0;
        bus.startOfFrame = 1'b0;
        bus.show_req = 1'b0;
        bus.msg_sel = '0;
        bus.clear = 1'b0;

        // Sweep the message area while reset is held.
        bad = 0;
        for (int y = 200; y <= 280; y += 2) begin
            for (int x = 180; x <= 460; x += 4) begin
                bus.pixelX = 11'(x);
                bus.pixelY = 11'(y);
                tick();
                if (bus.drawingRequest !== 1'b0 || bus.RGBout !== 8'h00 || bus.active !== 1'b0
                    || bus.reveal_done !== 1'b0)
                    bad++;
            end
        end
        check("reset_sweep_bad_pixels", 32'(bad), 32'd0);
        check("reset_rgb", 32'(bus.RGBout), 32'h00);

        resetN = 1'b1;
        tick();
        check("rgb_after_release", 32'(bus.RGBout), 32'hFF);
        check("active_idle", 32'(bus.active), 32'd0);
        probe("idle_no_draw", 192, 216, 1'b0);

        // WIN: full reveal then glyph spot checks.
        show(2'd0);
        probe("win_cnt0_hidden", 192, 216, 1'b0);
        run_reveal("win");
        probe("win_r2c0", 192, 216, 1'b1);
        probe("win_r2c0_subpix", 195, 219, 1'b1);
        probe("win_r2c1", 196, 216, 1'b1);
        probe("win_r2c3_clear", 204, 216, 1'b0);
        probe("win_r1_blank", 192, 212, 1'b0);
        probe("win_r11c2", 200, 252, 1'b1);
        probe("win_r12_blank", 200, 256, 1'b0);
        probe("win_char4_W", 320, 216, 1'b1);
        probe("win_space", 288, 216, 1'b0);
        probe("bound_x191", 191, 216, 1'b0);
        probe("bound_y207", 192, 207, 1'b0);
        probe("bound_x452", 452, 216, 1'b0);
        probe("bound_x0_bigy", 0, 1000, 1'b0);

        // LOSE mid-reveal: reveal_cnt = 4 after one frame.
        show(2'd1);
        probe("lose_restart_hidden", 192, 216, 1'b0);
        frame();
        check("lose_no_done", 32'(bus.reveal_done), 32'd0);
        probe("lose_c2_shown", 200, 216, 1'b1);
        probe("lose_c4_hidden", 208, 216, 1'b0);
        probe("lose_c5_hidden", 212, 216, 1'b0);

        // Restart to LEVEL UP coinciding with startOfFrame during WIN reveal.
        show(2'd0);
        frame();
        frame();
        bus.show_req = 1'b1;
        bus.msg_sel = 2'd3;
        bus.startOfFrame = 1'b1;
        tick();
        bus.show_req = 1'b0;
        bus.startOfFrame = 1'b0;
        probe("lvl_cnt0_hidden", 192, 216, 1'b0);
        frame();
        probe("lvl_c0_L", 192, 216, 1'b1);
        probe("lvl_c2_L_clear", 200, 216, 1'b0);
        early = 0;
        for (int i = 0; i < 15; i++) begin
            frame();
            early += int'(bus.reveal_done);
        end
        check("lvl_no_early_done", 32'(early), 32'd0);
        frame();
        check("lvl_done_17th", 32'(bus.reveal_done), 32'd1);
        probe("lvl_char4_L", 320, 216, 1'b1);

        // clear and show_req together: clear wins, request dropped.
        bus.clear = 1'b1;
        bus.show_req = 1'b1;
        bus.msg_sel = 2'd2;
        tick();
        bus.clear = 1'b0;
        bus.show_req = 1'b0;
        check("clear_wins_active", 32'(bus.active), 32'd0);
        frame();
        frame();
        check("clear_stays_idle", 32'(bus.active), 32'd0);
        probe("clear_no_draw", 192, 216, 1'b0);

        // PAUSED blink: on for 30 frames, off for 30, on again.
        show(2'd2);
        run_reveal("paused");
        probe("paused_on_start", 192, 216, 1'b1);
        for (int f = 1; f <= 60; f++) begin
            frame();
            probe($sformatf("blink_f%0d", f), 192, 216, (f < 30) || (f >= 60));
            check($sformatf("blink_active_f%0d", f), 32'(bus.active), 32'd1);
        end

        // Asynchronous reset mid-display.
        probe("pre_reset_on", 192, 216, 1'b1);
        resetN = 1'b0;
        #2;
        check("async_draw", 32'(bus.drawingRequest), 32'd0);
        check("async_rgb", 32'(bus.RGBout), 32'h00);
        check("async_active", 32'(bus.active), 32'd0);
        tick();
        resetN = 1'b1;
        tick();
        probe("post_reset_idle", 192, 216, 1'b0);
        check("post_reset_active", 32'(bus.active), 32'd0);
        show(2'd0);
        run_reveal("resume");
        probe("resume_r2c0", 192, 216, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/message_overlay.md
# message_overlay

Parametrised end-of-game / status text overlay for the VGA pipeline. It holds four fixed bitmap messages (WIN, LOSE, PAUSED, LEVEL UP) and draws the selected one at a scaled, parameter-set screen position. A left-to-right column wipe reveals each message, and PAUSED blinks at a frame-counted rate. It sits beside the other object drawers and feeds the objects mux through `drawingRequest` / `RGBout`.

## Interface
- `MSG_W`, 65: bitmap width in glyph pixels.
- `MSG_H`, 16: bitmap height in glyph pixels.
- `SCALE_BITS`, 2: each glyph pixel is drawn as a (1<<SCALE_BITS)² screen square.
- `TOP_LEFT_X`, 192: screen X of the message's left edge.
- `TOP_LEFT_Y`, 208: screen Y of the message's top edge.
- `REVEAL_STEP`, 4: glyph columns uncovered per frame during reveal.
- `BLINK_FRAMES`, 30: frames per on/off phase of the PAUSED blink.
- `FG_COLOR`, 8'hFF: RGB332 colour of set glyph pixels.
- `clk` in 1: pixel clock.
- `resetN` in 1: reset, asynchronous, active-low.
- `pixelX` in 11: current scan X.
- `pixelY` in 11: current scan Y.
- `startOfFrame` in 1: one-cycle pulse per frame.
- `show_req` in 1: one-cycle pulse that starts displaying `msg_sel`.
- `msg_sel` in 2: 0=WIN, 1=LOSE, 2=PAUSED, 3=LEVEL UP; sampled only when `show_req` is high.
- `clear` in 1: level or pulse; removes the overlay.
- `drawingRequest` out 1: registered; current pixel is a set glyph pixel.
- `RGBout` out 8: registered colour.
- `active` out 1: high whenever the state is not IDLE.
- `reveal_done` out 1: one-cycle pulse when the reveal completes.

## Operation
- ROM contents: four MSG_H×MSG_W bitmaps. Rows 0–1 and 12–15 are blank. Messages 0 and 1 start with "YOU": row 2 has cols 0–2 set and col 3 clear.
- Hit test uses unsigned offsets `dx = pixelX - TOP_LEFT_X` and `dy = pixelY - TOP_LEFT_Y`, computed 12 bits wide.
  - A hit requires pixelX ≥ TOP_LEFT_X and pixelY ≥ TOP_LEFT_Y; there is no negative wrap into the box.
  - A hit also requires `dx>>SCALE_BITS < MSG_W` and `dy>>SCALE_BITS < MSG_H`.
  - Glyph indices are `col = dx>>SCALE_BITS` and `row = dy>>SCALE_BITS`.
- States: IDLE, REVEAL, SHOW.
- IDLE:
  - Nothing is drawn.
  - `show_req` latches `msg_sel` into `msg_q`, sets `reveal_cnt`=0 and moves to REVEAL.
- REVEAL:
  - Each `startOfFrame` does `reveal_cnt += REVEAL_STEP`, saturating at MSG_W.
  - When `reveal_cnt` reaches MSG_W, the state moves to SHOW and `reveal_done` pulses in the same cycle.
  - Only columns with col < `reveal_cnt` are drawn.
- SHOW:
  - All columns are drawn.
  - If `msg_q`==2, `blink_cnt` counts `startOfFrame` pulses. At BLINK_FRAMES−1 it wraps to 0 and toggles `blink_on`. Drawing is suppressed while `blink_on`=0.
  - For other messages `blink_on` stays 1.
- `show_req` in REVEAL or SHOW: re-latches `msg_sel`, clears `reveal_cnt`, `blink_cnt` and `blink_on`:=1, and re-enters REVEAL. It always restarts, even for the same message.
- `clear` from any state goes to IDLE next cycle. `clear` and `show_req` in the same cycle: `clear` wins and the request is dropped.
- `show_req` coinciding with `startOfFrame`: the restart takes effect and that frame does not increment `reveal_cnt`.
- `drawingRequest` = hit ∧ bitmap[msg_q][row][col] ∧ visible, where visible is the state/reveal/blink condition.
- `RGBout` = FG_COLOR whenever not in reset.

## Timing
- Reset values:
  - State IDLE, `msg_q`=0, `reveal_cnt`=0, `blink_cnt`=0, `blink_on`=1.
  - `drawingRequest`=0, `RGBout`=8'h00, `active`=0, `reveal_done`=0.
- Latency: `drawingRequest` and `RGBout` for pixel (X,Y) appear 1 clk after (X,Y) is presented.
- `active` is registered and rises 1 clk after an accepted `show_req`.
- Reveal duration from `show_req`: ceil(MSG_W/REVEAL_STEP) `startOfFrame` pulses; with defaults, 17 pulses.
- Reset asserted mid-operation forces the reset values immediately (asynchronous). Display resumes only after a new `show_req`.

## Test plan
- After reset, sweep the full frame → `drawingRequest`=0 everywhere, `active`=0, `RGBout`=8'h00 until the first clk after release.
- show_req with msg_sel=0, then 17 `startOfFrame` pulses → `reveal_done` pulses once on the 17th. Then pixel (192,216), i.e. row 2 col 0, gives `drawingRequest`=1 one clk later; (204,216), col 3, gives 0.
- Mid-reveal check: show_req with msg=1, then 1 frame (`reveal_cnt`=4) → col 2 at X=200,Y=216 gives 1; pixel in col 5 (X=212) gives 0 regardless of the bitmap.
- Bounds check: pixelX=191 or pixelY=207 → 0; X=192+65·4=452 → 0. No hit at pixelX=0 with large Y.
- PAUSED blink: show msg=2, complete the reveal, then count frames → drawing is on for 30 frames, off for 30, on again. `active` stays 1 throughout.
- Simultaneous events: `clear` and `show_req` asserted together in SHOW → IDLE, `active`=0. `show_req` with msg=3 during REVEAL of msg 0 → `reveal_cnt` restarts at 0 and the msg 3 bitmap is drawn.
